// File: rtl/schedule_queue_pkg.sv
// Shared definitions for the schedule queue: field widths, the entry layout
// and the opcode value that marks a decode bubble.
package schedule_pkg;

  localparam int OPCODE_W   = 17;
  localparam int RD_W       = 5;
  localparam int CSR_W      = 12;
  localparam int SCHED_XLEN = 32;

  localparam logic [OPCODE_W-1:0] NOP_OPCODE = '0;

  // Field order matches the packed concatenation held in the queue storage,
  // so a stored word can be viewed directly as this struct.
  typedef struct packed {
    logic [SCHED_XLEN-1:0] pc;
    logic [OPCODE_W-1:0]   opcode;
    logic [RD_W-1:0]       rd;
    logic [CSR_W-1:0]      csr;
    logic [SCHED_XLEN-1:0] imm;
  } sched_entry_t;

endpackage

// File: rtl/schedule_queue_if.sv
// Decode2-side and execute-side handshake bundle of the schedule queue.
// The master modport is the surrounding pipeline; the slave is the queue.
interface schedule_queue_if
  import schedule_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
);

  logic                FLUSH;
  logic                STALL;
  logic                MEM_WAIT;
  logic                IN_VALID;
  logic                IN_READY;
  logic [XLEN-1:0]     PC;
  logic [OPCODE_W-1:0] OPCODE;
  logic [RD_W-1:0]     RD;
  logic [CSR_W-1:0]    CSR;
  logic [XLEN-1:0]     IMM;
  logic                SCHEDULE_VALID;
  logic                EXEC_READY;
  logic [XLEN-1:0]     SCHEDULE_PC;
  logic [OPCODE_W-1:0] SCHEDULE_OPCODE;
  logic [RD_W-1:0]     SCHEDULE_RD;
  logic [CSR_W-1:0]    SCHEDULE_CSR;
  logic [XLEN-1:0]     SCHEDULE_IMM;
  logic [CNT_W-1:0]    SCHEDULE_COUNT;

  modport master (
    output FLUSH, STALL, MEM_WAIT, IN_VALID, PC, OPCODE, RD, CSR, IMM, EXEC_READY,
    input  IN_READY, SCHEDULE_VALID, SCHEDULE_PC, SCHEDULE_OPCODE, SCHEDULE_RD,
           SCHEDULE_CSR, SCHEDULE_IMM, SCHEDULE_COUNT
  );

  modport slave (
    input  FLUSH, STALL, MEM_WAIT, IN_VALID, PC, OPCODE, RD, CSR, IMM, EXEC_READY,
    output IN_READY, SCHEDULE_VALID, SCHEDULE_PC, SCHEDULE_OPCODE, SCHEDULE_RD,
           SCHEDULE_CSR, SCHEDULE_IMM, SCHEDULE_COUNT
  );

endinterface

// File: rtl/schedule_queue_mem.sv
// DEPTH-entry register file backing the schedule queue: one synchronous
// write port, one asynchronous read port. Storage is not reset because
// occupancy is tracked entirely by the pointers and count in the parent.
module schedule_queue_mem #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 98,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wrEn_i,
  input  logic [AW-1:0]    wrAddr_i,
  input  logic [WIDTH-1:0] wrData_i,
  input  logic [AW-1:0]    rdAddr_i,
  output logic [WIDTH-1:0] rdData_o
);

  logic [WIDTH-1:0] storage_q [DEPTH];

  // Write the incoming entry into its slot on a push edge.
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      storage_q[wrAddr_i] <= wrData_i;
    end
  end

  assign rdData_o = storage_q[rdAddr_i];

endmodule

// File: rtl/schedule_queue.sv
// In-order circular queue between decode stage 2 and execute. Holds up to
// DEPTH decoded instructions, optionally discards NOP bubbles at the input,
// and presents a zeroed (NOP) head whenever it is empty.
module schedule_queue
  import schedule_pkg::*;
#(
  parameter  int DEPTH    = 4,
  parameter  int XLEN     = 32,
  parameter  int DROP_NOP = 1,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input logic CLK,
  input logic RST_N,
  schedule_queue_if.slave bus
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam int              ENTRY_W  = 2 * XLEN + OPCODE_W + RD_W + CSR_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam bit              DROP_EN  = (DROP_NOP != 0);

  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               inReady, headValid, isNop, accept, push, pop;
  logic [ENTRY_W-1:0] wrEntry, rdEntry;

  // Ready and valid come only from registered occupancy, so a full queue
  // refuses input even if the head leaves in the same cycle.
  assign inReady   = (count_q != FULL_CNT);
  assign headValid = (count_q != '0);
  assign isNop     = (bus.OPCODE == NOP_OPCODE);
  assign accept    = bus.IN_VALID & inReady & ~bus.FLUSH;
  assign push      = accept & ~(DROP_EN & isNop);
  assign pop       = headValid & bus.EXEC_READY & ~bus.STALL & ~bus.MEM_WAIT & ~bus.FLUSH;
  assign wrEntry   = {bus.PC, bus.OPCODE, bus.RD, bus.CSR, bus.IMM};

  // Next pointers and occupancy; a flush wins over everything and rewinds
  // both pointers to slot zero.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (bus.FLUSH) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers; reset empties the queue immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  schedule_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk_i    (CLK),
    .wrEn_i   (push),
    .wrAddr_i (wrPtr_q),
    .wrData_i (wrEntry),
    .rdAddr_i (rdPtr_q),
    .rdData_o (rdEntry)
  );

  assign bus.IN_READY       = inReady;
  assign bus.SCHEDULE_VALID = headValid;
  assign bus.SCHEDULE_COUNT = count_q;
  assign {bus.SCHEDULE_PC, bus.SCHEDULE_OPCODE, bus.SCHEDULE_RD,
          bus.SCHEDULE_CSR, bus.SCHEDULE_IMM} = headValid ? rdEntry : '0;

endmodule

// File: tb/tb_schedule_queue.sv
// Bench for schedule_queue: a directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_schedule_queue;
  import schedule_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  typedef struct {
    logic        flush, stall, memWait, inValid, execReady;
    logic [31:0] pc;
    logic [16:0] opcode;
    logic [4:0]  rd;
    logic [11:0] csr;
    logic [31:0] imm;
  } stim_t;

  typedef struct {
    stim_t       s;
    int          expCount;
    logic        expValid;
    logic        expReady;
    logic [31:0] expPc;
  } vec_t;

  logic CLK = 1'b0;
  logic RST_N;
  int   testsRun    = 0;
  int   testsFailed = 0;

  sched_entry_t modelQ[$];

  schedule_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  schedule_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .DROP_NOP(1)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  function automatic stim_t mk(input logic flush, input logic stall, input logic memWait,
                               input logic inValid, input logic execReady,
                               input logic [31:0] pc, input logic [16:0] opcode);
    stim_t s;
    s.flush = flush; s.stall = stall; s.memWait = memWait;
    s.inValid = inValid; s.execReady = execReady;
    s.pc = pc; s.opcode = opcode;
    s.rd = pc[6:2]; s.csr = pc[11:0] + 12'h1; s.imm = pc ^ 32'hDEAD_BEEF;
    return s;
  endfunction

  task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour at a clock edge, expressed as queue operations.
  task automatic modelEdge(input stim_t s);
    sched_entry_t e;
    bit ready, valid, doPush, doPop;
    ready = modelQ.size() < DEPTH;
    valid = modelQ.size() > 0;
    if (s.flush) begin
      modelQ.delete();
      return;
    end
    doPush = s.inValid && ready && (s.opcode != 17'd0);
    doPop  = valid && s.execReady && !s.stall && !s.memWait;
    if (doPop) void'(modelQ.pop_front());
    if (doPush) begin
      e.pc = s.pc; e.opcode = s.opcode; e.rd = s.rd; e.csr = s.csr; e.imm = s.imm;
      modelQ.push_back(e);
    end
  endtask

  task automatic checkOutput(input string tag);
    sched_entry_t expHead;
    expHead = (modelQ.size() > 0) ? modelQ[0] : '0;
    checkVal({tag, ".count"}, 128'(bus.SCHEDULE_COUNT), 128'(modelQ.size()));
    checkVal({tag, ".valid"}, 128'(bus.SCHEDULE_VALID), 128'(modelQ.size() > 0));
    checkVal({tag, ".ready"}, 128'(bus.IN_READY), 128'(modelQ.size() < DEPTH));
    checkVal({tag, ".head"},
             128'({bus.SCHEDULE_PC, bus.SCHEDULE_OPCODE, bus.SCHEDULE_RD,
                   bus.SCHEDULE_CSR, bus.SCHEDULE_IMM}),
             128'(expHead));
  endtask

  // Drive one cycle of inputs, let the edge happen, then check at the
  // falling edge.
  task automatic applyStimulus(input stim_t s, input string tag);
    bus.FLUSH = s.flush; bus.STALL = s.stall; bus.MEM_WAIT = s.memWait;
    bus.IN_VALID = s.inValid; bus.EXEC_READY = s.execReady;
    bus.PC = s.pc; bus.OPCODE = s.opcode; bus.RD = s.rd; bus.CSR = s.csr; bus.IMM = s.imm;
    @(posedge CLK);
    modelEdge(s);
    @(negedge CLK);
    checkOutput(tag);
  endtask

  vec_t vecs[$];

  initial begin
    stim_t s;

    // Directed table: single push/pop, then fill past full and drain.
    vecs.push_back('{mk(0,0,0,1,1,32'h100,17'h13), 1, 1'b1, 1'b1, 32'h100});
    vecs.push_back('{mk(0,0,0,0,1,32'h0,  17'h0 ), 0, 1'b0, 1'b1, 32'h0  });
    vecs.push_back('{mk(0,0,0,1,0,32'h0,  17'h13), 1, 1'b1, 1'b1, 32'h0  });
    vecs.push_back('{mk(0,0,0,1,0,32'h4,  17'h13), 2, 1'b1, 1'b1, 32'h0  });
    vecs.push_back('{mk(0,0,0,1,0,32'h8,  17'h13), 3, 1'b1, 1'b1, 32'h0  });
    vecs.push_back('{mk(0,0,0,1,0,32'hC,  17'h13), 4, 1'b1, 1'b0, 32'h0  });
    vecs.push_back('{mk(0,0,0,1,0,32'h10, 17'h13), 4, 1'b1, 1'b0, 32'h0  });
    vecs.push_back('{mk(0,0,0,0,1,32'h0,  17'h0 ), 3, 1'b1, 1'b1, 32'h4  });
    vecs.push_back('{mk(0,0,0,0,1,32'h0,  17'h0 ), 2, 1'b1, 1'b1, 32'h8  });
    vecs.push_back('{mk(0,0,0,0,1,32'h0,  17'h0 ), 1, 1'b1, 1'b1, 32'hC  });
    vecs.push_back('{mk(0,0,0,0,1,32'h0,  17'h0 ), 0, 1'b0, 1'b1, 32'h0  });

    s = mk(0,0,0,0,0,32'h0,17'h0);
    bus.FLUSH = 0; bus.STALL = 0; bus.MEM_WAIT = 0; bus.IN_VALID = 0; bus.EXEC_READY = 0;
    bus.PC = '0; bus.OPCODE = '0; bus.RD = '0; bus.CSR = '0; bus.IMM = '0;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s, $sformatf("vec%0d", i));
      checkVal($sformatf("vec%0d.tcount", i), 128'(bus.SCHEDULE_COUNT), 128'(vecs[i].expCount));
      checkVal($sformatf("vec%0d.tvalid", i), 128'(bus.SCHEDULE_VALID), 128'(vecs[i].expValid));
      checkVal($sformatf("vec%0d.tready", i), 128'(bus.IN_READY), 128'(vecs[i].expReady));
      checkVal($sformatf("vec%0d.tpc", i), 128'(bus.SCHEDULE_PC), 128'(vecs[i].expPc));
    end

    // STALL then MEM_WAIT freeze the head; a push still lands during stall.
    applyStimulus(mk(0,0,0,1,0,32'h200,17'h13), "stallFill0");
    applyStimulus(mk(0,0,0,1,0,32'h204,17'h13), "stallFill1");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(0,1,0,0,1,32'h0,17'h0), "stall");
      checkVal("stall.pc", 128'(bus.SCHEDULE_PC), 128'(32'h200));
      checkVal("stall.cnt", 128'(bus.SCHEDULE_COUNT), 128'(2));
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(0,0,1,0,1,32'h0,17'h0), "memWait");
      checkVal("memWait.pc", 128'(bus.SCHEDULE_PC), 128'(32'h200));
      checkVal("memWait.cnt", 128'(bus.SCHEDULE_COUNT), 128'(2));
    end
    applyStimulus(mk(0,1,0,1,1,32'h208,17'h13), "stallPush");
    checkVal("stallPush.cnt", 128'(bus.SCHEDULE_COUNT), 128'(3));
    checkVal("stallPush.pc", 128'(bus.SCHEDULE_PC), 128'(32'h200));
    for (int i = 0; i < 3; i++) applyStimulus(mk(0,0,0,0,1,32'h0,17'h0), "stallDrain");

    // FLUSH with a same-cycle input: everything cleared, input not stored.
    applyStimulus(mk(0,0,0,1,0,32'h300,17'h13), "flushFill0");
    applyStimulus(mk(0,0,0,1,0,32'h304,17'h13), "flushFill1");
    applyStimulus(mk(0,0,0,1,0,32'h308,17'h13), "flushFill2");
    applyStimulus(mk(1,0,0,1,1,32'h999,17'h13), "flush");
    checkVal("flush.valid", 128'(bus.SCHEDULE_VALID), 128'(0));
    checkVal("flush.cnt", 128'(bus.SCHEDULE_COUNT), 128'(0));
    checkVal("flush.data", 128'({bus.SCHEDULE_PC, bus.SCHEDULE_OPCODE, bus.SCHEDULE_RD,
                                 bus.SCHEDULE_CSR, bus.SCHEDULE_IMM}), 128'(0));
    applyStimulus(mk(0,0,0,0,0,32'h0,17'h0), "postFlush");
    checkVal("postFlush.cnt", 128'(bus.SCHEDULE_COUNT), 128'(0));

    // NOP bubbles are accepted but never stored.
    checkVal("nop.readyBefore", 128'(bus.IN_READY), 128'(1));
    applyStimulus(mk(0,0,0,1,0,32'h400,17'h0), "nopIn");
    checkVal("nopIn.cnt", 128'(bus.SCHEDULE_COUNT), 128'(0));
    checkVal("nopIn.ready", 128'(bus.IN_READY), 128'(1));
    applyStimulus(mk(0,0,0,1,0,32'h404,17'h33), "realIn");
    checkVal("realIn.cnt", 128'(bus.SCHEDULE_COUNT), 128'(1));
    checkVal("realIn.op", 128'(bus.SCHEDULE_OPCODE), 128'(17'h33));
    applyStimulus(mk(0,0,0,0,1,32'h0,17'h0), "nopDrain");

    // Simultaneous push and pop to walk the pointers around the ring.
    applyStimulus(mk(0,0,0,1,0,32'h500,17'h13), "wrapFill0");
    applyStimulus(mk(0,0,0,1,0,32'h504,17'h13), "wrapFill1");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(mk(0,0,0,1,1,32'h508 + 32'(4 * i),17'h13), "wrap");
      checkVal("wrap.cnt", 128'(bus.SCHEDULE_COUNT), 128'(2));
      checkVal("wrap.pc", 128'(bus.SCHEDULE_PC), 128'(32'h500 + 32'(4 * (i + 1))));
    end

    // Asynchronous reset mid-stream clears outputs without a clock edge.
    #2 RST_N = 1'b0;
    #1;
    checkVal("asyncRst.valid", 128'(bus.SCHEDULE_VALID), 128'(0));
    checkVal("asyncRst.cnt", 128'(bus.SCHEDULE_COUNT), 128'(0));
    checkVal("asyncRst.pc", 128'(bus.SCHEDULE_PC), 128'(0));
    checkVal("asyncRst.ready", 128'(bus.IN_READY), 128'(1));
    modelQ.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    checkOutput("afterRst");

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      s = mk($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom,
             ($urandom_range(0, 4) == 0) ? 17'h0 : 17'($urandom));
      applyStimulus(s, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/schedule_queue.md
Name: schedule_queue

Overview:
Parametrised successor to the single-register schedule stage.
- Sits between decode stage 2 and the execute stage.
- Buffers up to DEPTH decoded instructions in an in-order circular queue.
- Uses valid/ready handshakes on both sides, plus FLUSH, STALL and MEM_WAIT control.
- Drops NOP bubbles at the input when configured to, which decouples decode from execute back-pressure.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
XLEN, 32, width of PC and IMM
DROP_NOP, 1, when 1 an input with OPCODE==0 is accepted but not stored
CNT_W, $clog2(DEPTH+1), width of SCHEDULE_COUNT (derived; do not override)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
FLUSH  in  1  synchronous queue clear (branch/trap)
STALL  in  1  hold dequeue
MEM_WAIT  in  1  hold dequeue
IN_VALID  in  1  decode2 entry valid
IN_READY  out  1  queue can accept an entry
PC  in  XLEN  instruction PC
OPCODE  in  17  decoded opcode
RD  in  5  destination register
CSR  in  12  CSR address
IMM  in  XLEN  immediate
SCHEDULE_VALID  out  1  head entry valid
EXEC_READY  in  1  execute accepts the head entry
SCHEDULE_PC  out  XLEN  head PC
SCHEDULE_OPCODE  out  17  head opcode
SCHEDULE_RD  out  5  head RD
SCHEDULE_CSR  out  12  head CSR
SCHEDULE_IMM  out  XLEN  head IMM
SCHEDULE_COUNT  out  CNT_W  occupied entries

Behaviour:
- Reset (RST_N low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; storage contents are don't-care.
  - SCHEDULE_VALID=0, all SCHEDULE_* data = 0, SCHEDULE_COUNT=0, IN_READY=1.
  - Reset asserted mid-operation discards all entries immediately.
- IN_READY = (count != DEPTH). It is a registered-state function only, with no combinational path from EXEC_READY. A full queue does not accept an entry even when a pop occurs in the same cycle.
- accept = IN_VALID & IN_READY & ~FLUSH.
- push = accept & ~(DROP_NOP & OPCODE==0). An accepted NOP is consumed with no state change.
- pop = SCHEDULE_VALID & EXEC_READY & ~STALL & ~MEM_WAIT & ~FLUSH.
- On push: write {PC,OPCODE,RD,CSR,IMM} at wr_ptr; wr_ptr += 1 mod DEPTH.
- On pop: rd_ptr += 1 mod DEPTH.
- count update: push only, +1; pop only, -1; both, unchanged.
- Push into an empty queue at edge k makes SCHEDULE_VALID=1 after edge k (latency 1). There is no combinational input-to-output bypass.
- SCHEDULE_VALID = (count != 0).
- SCHEDULE_* data = entry[rd_ptr] when valid, else all zeros (NOP, which keeps the execute stage's bubble semantics).
- FLUSH (synchronous):
  - Next edge sets count=0 and rd_ptr=wr_ptr=0.
  - Drops any same-cycle push and suppresses pop.
  - FLUSH has priority over STALL, MEM_WAIT and pushes.
- STALL or MEM_WAIT freezes the head and outputs. Pushes continue while IN_READY=1.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count, not by pointer equality.
- Ordering: strictly FIFO; entries leave in arrival order.

Decomposition:
- Package schedule_pkg holds:
  - Field widths: OPCODE_W=17, RD_W=5, CSR_W=12.
  - The packed entry struct sched_entry_t {pc, opcode, rd, csr, imm}.
  - The localparam NOP_OPCODE=0.
- One natural sub-module, schedule_queue_mem: DEPTH x entry register file, one synchronous write port, one asynchronous read port, no reset on storage.
- Pointer, count and handshake logic stay in schedule_queue.

Test Plan:
- Reset then push PC=0x100, OPCODE=0x13, EXEC_READY=1 -> SCHEDULE_VALID=1 and SCHEDULE_PC=0x100 one cycle later; popped next edge; SCHEDULE_COUNT returns 0.
- EXEC_READY=0, push 5 entries PC=0x0,0x4,...,0x10 with DEPTH=4 -> IN_READY=0 after the 4th push; the 5th entry is not accepted; then EXEC_READY=1 -> outputs 0x0,0x4,0x8,0xC in order.
- Queue holds 2 entries, STALL=1 for 3 cycles with EXEC_READY=1 -> head PC unchanged and count stays 2; MEM_WAIT=1 behaves identically.
- Queue holds 3 entries, FLUSH=1 together with IN_VALID=1 -> next cycle SCHEDULE_VALID=0, all outputs 0, count=0, the flushed-cycle input is not stored.
- DROP_NOP=1, feed OPCODE=0 then OPCODE=0x33 -> IN_READY=1 for both; only 0x33 appears; count peaks at 1.
- Run 10 push/pop cycles with simultaneous push and pop to force pointer wrap (DEPTH=4) -> count constant, output sequence matches the input sequence; RST_N pulsed low mid-stream -> outputs zero immediately, without waiting for a clock edge.
